pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_slot.sv | 55 +++++
 rtl/pipe_stage_reg.sv | 160 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage register: occupancy state and its counter width.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_e;

  localparam int OCC_W = 2;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry (valid, ctrl, data) with load and clear; updates one cycle after load.
// No flow control of its own: the owning stage decides when to load or clear.
module pipe_slot #(
  parameter int                 DATA_W   = 128,
  parameter int                 CTRL_W   = 12,
  parameter logic [CTRL_W-1:0]  NOP_CTRL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // Clear wins over load so a discarded entry never leaves side effects behind.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = NOP_CTRL;
      data_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= NOP_CTRL;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional skid entry, flush/stall obedience; one-cycle latency.
// SKID_EN=1: ready from registered state only; SKID_EN=0: ready = !out_valid | out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W   = 128,
  parameter int                 CTRL_W   = 12,
  parameter logic [CTRL_W-1:0]  NOP_CTRL = '0,
  parameter bit                 SKID_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [OCC_W-1:0]  occupancy_o
);

  state_e state_q, state_d;
  logic   init_q, init_d;

  logic              accept, drain;
  logic              main_load, main_clear, main_from_skid;
  logic              skid_load, skid_clear;
  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
  logic [DATA_W-1:0] main_data, skid_data, main_data_in;

  // Holds ready low while in reset and until the first edge after release.
  assign init_d = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
    end
  end

  always_comb begin
    if (SKID_EN) in_ready_o = init_q & !stall_i & (state_q != SKID);
    else         in_ready_o = init_q & !stall_i & (!out_valid_o | out_ready_i);
  end

  assign accept = in_valid_i & in_ready_o & !stall_i & !flush_i;
  assign drain  = out_valid_o & out_ready_i & !stall_i & !flush_i;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush_i) begin
      state_d    = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = FULL;
            main_load = 1'b1;
          end
        end
        FULL: begin
          if (accept && drain) begin
            main_load = 1'b1;
          end else if (drain) begin
            state_d    = EMPTY;
            main_clear = 1'b1;
          end else if (accept && SKID_EN) begin
            state_d   = SKID;
            skid_load = 1'b1;
          end
        end
        SKID: begin
          // Skid only ever feeds main, keeping the two entries in arrival order.
          if (drain) begin
            state_d        = FULL;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          state_d    = EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl_i;
  assign main_data_in = main_from_skid ? skid_data : in_data_i;

  pipe_slot #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .NOP_CTRL (NOP_CTRL)
  ) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (main_load),
    .clear_i (main_clear),
    .ctrl_i  (main_ctrl_in),
    .data_i  (main_data_in),
    .valid_o (main_valid),
    .ctrl_o  (main_ctrl),
    .data_o  (main_data)
  );

  generate
    if (SKID_EN) begin : g_skid
      pipe_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .NOP_CTRL (NOP_CTRL)
      ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .ctrl_i  (in_ctrl_i),
        .data_i  (in_data_i),
        .valid_o (skid_valid),
        .ctrl_o  (skid_ctrl),
        .data_o  (skid_data)
      );
    end else begin : g_no_skid
      assign skid_valid = 1'b0;
      assign skid_ctrl  = NOP_CTRL;
      assign skid_data  = '0;
    end
  endgenerate

  assign out_valid_o = main_valid;
  assign out_ctrl_o  = main_valid ? main_ctrl : NOP_CTRL;
  assign out_data_o  = main_valid ? main_data : '0;

  always_comb begin
    unique case (state_q)
      FULL:    occupancy_o = OCC_W'(1);
      SKID:    occupancy_o = OCC_W'(2);
      default: occupancy_o = OCC_W'(0);
    endcase
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: skid-enabled stage driven from a vector table, plus hand sequences
// for async reset and the SKID_EN=0 variant.
module tb_pipe_stage_reg;

  localparam logic [11:0] NOP0 = 12'h5A5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_stall, a_flush;
  logic [11:0]   a_in_ctrl, a_out_ctrl;
  logic [127:0]  a_in_data, a_out_data;
  logic [1:0]    a_occ;

  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_stall, b_flush;
  logic [11:0]   b_in_ctrl, b_out_ctrl;
  logic [15:0]   b_in_data, b_out_data;
  logic [1:0]    b_occ;

  pipe_stage_reg dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_ctrl_i(a_in_ctrl), .in_data_i(a_in_data),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_ctrl_o(a_out_ctrl), .out_data_o(a_out_data),
    .stall_i(a_stall), .flush_i(a_flush), .occupancy_o(a_occ)
  );

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(12), .NOP_CTRL(NOP0), .SKID_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_ctrl_i(b_in_ctrl), .in_data_i(b_in_data),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_ctrl_o(b_out_ctrl), .out_data_o(b_out_data),
    .stall_i(b_stall), .flush_i(b_flush), .occupancy_o(b_occ)
  );

  typedef struct {
    logic         v;
    logic [11:0]  c;
    logic [127:0] d;
    logic         ordy, stall, flush;
    logic         e_rdy, e_v;
    logic [11:0]  e_c;
    logic [127:0] e_d;
    logic [1:0]   e_occ;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic v, input logic [11:0] c, input logic [127:0] d,
                     input logic ordy, input logic stall, input logic flush,
                     input logic e_rdy, input logic e_v, input logic [11:0] e_c,
                     input logic [127:0] e_d, input logic [1:0] e_occ);
    vec_t t;
    t.v = v; t.c = c; t.d = d; t.ordy = ordy; t.stall = stall; t.flush = flush;
    t.e_rdy = e_rdy; t.e_v = e_v; t.e_c = e_c; t.e_d = e_d; t.e_occ = e_occ;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    a_in_valid = 0; a_in_ctrl = 0; a_in_data = 0; a_out_ready = 0; a_stall = 0; a_flush = 0;
    b_in_valid = 0; b_in_ctrl = 0; b_in_data = 0; b_out_ready = 0; b_stall = 0; b_flush = 0;

    // Reset values, with a clock edge passing while reset is held.
    #7;
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_ctrl",  a_out_ctrl,  0);
    chk("rst_a_data",  a_out_data,  0);
    chk("rst_a_occ",   a_occ,       0);
    chk("rst_a_rdy",   a_in_ready,  0);
    chk("rst_b_ctrl",  b_out_ctrl,  NOP0);
    chk("rst_b_valid", b_out_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_a_rdy", a_in_ready, 1);
    chk("rel_b_rdy", b_in_ready, 1);

    //   v  ctrl     data        ordy st fl   rdy v  e_ctrl   e_data    occ
    add(1, 12'h001, 128'hA5,    1,   0, 0,   1,  1, 12'h001, 128'hA5,  2'd1);
    add(1, 12'h002, 128'h11,    1,   0, 0,   1,  1, 12'h002, 128'h11,  2'd1);
    add(0, 12'h000, 128'h0,     1,   0, 0,   1,  0, 12'h000, 128'h0,   2'd0);
    add(1, 12'h003, 128'hD1,    0,   0, 0,   1,  1, 12'h003, 128'hD1,  2'd1);
    add(1, 12'h004, 128'hD2,    0,   0, 0,   1,  1, 12'h003, 128'hD1,  2'd2);
    add(1, 12'h005, 128'hEE,    0,   0, 0,   0,  1, 12'h003, 128'hD1,  2'd2);
    add(0, 12'h000, 128'h0,     1,   0, 0,   0,  1, 12'h004, 128'hD2,  2'd1);
    add(0, 12'h000, 128'h0,     1,   0, 0,   1,  0, 12'h000, 128'h0,   2'd0);
    add(1, 12'h007, 128'h31,    0,   0, 0,   1,  1, 12'h007, 128'h31,  2'd1);
    add(1, 12'h008, 128'h32,    0,   0, 0,   1,  1, 12'h007, 128'h31,  2'd2);
    add(1, 12'h009, 128'hD3,    0,   0, 1,   0,  0, 12'h000, 128'h0,   2'd0);
    add(0, 12'h000, 128'h0,     1,   0, 0,   1,  0, 12'h000, 128'h0,   2'd0);
    add(1, 12'h00A, 128'hD4,    0,   0, 0,   1,  1, 12'h00A, 128'hD4,  2'd1);
    add(1, 12'h00B, 128'h77,    1,   1, 0,   0,  1, 12'h00A, 128'hD4,  2'd1);
    add(1, 12'h00B, 128'h77,    1,   1, 0,   0,  1, 12'h00A, 128'hD4,  2'd1);
    add(1, 12'h00B, 128'h77,    1,   1, 0,   0,  1, 12'h00A, 128'hD4,  2'd1);
    add(0, 12'h000, 128'h0,     1,   0, 0,   1,  0, 12'h000, 128'h0,   2'd0);
    add(1, 12'h00C, 128'h55,    0,   0, 0,   1,  1, 12'h00C, 128'h55,  2'd1);
    add(1, 12'h00D, 128'h66,    0,   1, 1,   0,  0, 12'h000, 128'h0,   2'd0);
    add(1, 12'hFFF, '1,         1,   0, 0,   1,  1, 12'hFFF, '1,       2'd1);
    add(0, 12'h000, 128'h0,     1,   0, 0,   1,  0, 12'h000, 128'h0,   2'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      a_in_valid = vecs[i].v; a_in_ctrl = vecs[i].c; a_in_data = vecs[i].d;
      a_out_ready = vecs[i].ordy; a_stall = vecs[i].stall; a_flush = vecs[i].flush;
      #1;
      chk($sformatf("v%0d_rdy", i), a_in_ready, vecs[i].e_rdy);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), a_out_valid, vecs[i].e_v);
      chk($sformatf("v%0d_ctrl", i),  a_out_ctrl,  vecs[i].e_c);
      chk($sformatf("v%0d_data", i),  a_out_data,  vecs[i].e_d);
      chk($sformatf("v%0d_occ", i),   a_occ,       vecs[i].e_occ);
    end

    // Async reset between edges while two entries are held.
    @(negedge clk);
    a_in_valid = 1; a_in_ctrl = 12'h081; a_in_data = 128'h81; a_out_ready = 0; a_stall = 0; a_flush = 0;
    @(negedge clk);
    a_in_ctrl = 12'h082; a_in_data = 128'h82;
    @(negedge clk);
    a_in_valid = 0;
    chk("ar_pre_occ", a_occ, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", a_out_valid, 0);
    chk("ar_ctrl",  a_out_ctrl,  0);
    chk("ar_data",  a_out_data,  0);
    chk("ar_occ",   a_occ,       0);
    chk("ar_rdy",   a_in_ready,  0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ar_rel_rdy", a_in_ready, 1);
    chk("ar_rel_occ", a_occ, 0);

    // SKID_EN=0: streaming one entry per cycle, then same-cycle ready drop.
    for (int k = 1; k <= 4; k++) begin
      logic [15:0] dv;
      dv = 16'(k * 16'h1111);
      @(negedge clk);
      b_in_valid = 1; b_in_ctrl = 12'(12'h100 + k); b_in_data = dv; b_out_ready = 1;
      #1;
      chk($sformatf("s%0d_rdy", k), b_in_ready, 1);
      @(posedge clk); #1;
      chk($sformatf("s%0d_data", k), b_out_data, dv);
      chk($sformatf("s%0d_ctrl", k), b_out_ctrl, 12'(12'h100 + k));
      chk($sformatf("s%0d_occ", k),  b_occ, 1);
    end
    @(negedge clk);
    b_out_ready = 0; b_in_data = 16'hBEEF;
    #1;
    chk("s_drop_rdy", b_in_ready, 0);
    @(posedge clk); #1;
    chk("s_hold_data", b_out_data, 16'h4444);
    chk("s_hold_occ", b_occ, 1);
    @(negedge clk);
    b_out_ready = 1; b_in_valid = 0;
    #1;
    chk("s_drain_rdy", b_in_ready, 1);
    @(posedge clk); #1;
    chk("s_empty_valid", b_out_valid, 0);
    chk("s_empty_ctrl",  b_out_ctrl,  NOP0);
    chk("s_empty_data",  b_out_data,  0);
    chk("s_empty_occ",   b_occ,       0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
